onewire_pin_ctrl: RTL and testbench
===================================

Name: onewire_pin_ctrl

Overview:
- Parametrised multi-channel bidirectional pin controller for single-wire sensor buses (DHT11-class).
- Per channel:
  - direction-controlled tristate drive, push-pull or open-drain;
  - always-on input synchroniser and glitch filter;
  - edge detection and level-width measurement;
  - self-timed host start pulse (drive low for N cycles, then release).
- Sits between top-level inout pins and the sensor protocol FSMs, replacing the plain per-pin tristate.

Parameters:
- CHANNELS, 1, number of independent pins.
- CNT_W, 16, width of the pulse-length and level-width counters.
- FILTER_LEN, 3, consecutive stable synchronised samples required to accept a level change (min 1).
- OPEN_DRAIN, 1, 1: drive only logic 0, release (Z) for 1; 0: push-pull drive of i_Send.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  synchronous active-high reset.
- i_Port  inout  CHANNELS  bus pins.
- i_Dir  in  CHANNELS  1 = output mode, 0 = input (released).
- i_Send  in  CHANNELS  drive value in output mode.
- i_Start  in  CHANNELS  request start pulse on channel c (sampled when idle).
- i_Pulse_Len  in  CNT_W  start pulse length in clocks, shared, sampled with i_Start.
- o_Read  out  CHANNELS  filtered pin level.
- o_Rise  out  CHANNELS  1-cycle strobe, filtered 0->1.
- o_Fall  out  CHANNELS  1-cycle strobe, filtered 1->0.
- o_Width  out  CHANNELS*CNT_W  duration in clocks of the level that just ended.
- o_Width_Valid  out  CHANNELS  1-cycle strobe, coincident with o_Rise|o_Fall.
- o_Busy  out  CHANNELS  start pulse in progress.
- o_Done  out  CHANNELS  1-cycle strobe at start pulse completion.

Behaviour:
- One clock (i_Clk); reset i_Rst is synchronous, active-high.
- Reset values:
  - o_Read = all 1 (idle-high bus); synchroniser and filter state = 1.
  - o_Rise, o_Fall, o_Width_Valid, o_Busy, o_Done = 0; o_Width = 0.
  - Width counters = 0; FSMs = IDLE.
- Pin drive, combinational, per channel:
  - PULSE state: drive 0.
  - Otherwise, i_Dir = 1: OPEN_DRAIN = 1 drives 0 when i_Send = 0, else Z; OPEN_DRAIN = 0 drives i_Send.
  - Otherwise i_Dir = 0: Z.
- Read path is always active, including in output mode, so open-drain readback works.
- Synchroniser: 2 flops (sync2).
- Filter: a counter tracks consecutive cycles with sync2 != o_Read. It clears when they are equal. When it reaches FILTER_LEN, o_Read takes sync2 on the next edge and the counter clears.
- Latency: a clean pin step appears on o_Read exactly 2+FILTER_LEN clocks after the first sampling edge. Pulses shorter than FILTER_LEN synchronised samples are rejected.
- Edge strobes: o_Rise/o_Fall are registered and high for the single cycle after o_Read changes.
- Width measurement:
  - A per-channel counter increments each cycle and saturates at 2^CNT_W-1 (no wrap).
  - On a filtered edge: o_Width[c] <= counter value (clocks the previous level was held) and o_Width_Valid pulses with the edge strobe. The counter then restarts at 1.
  - The first edge after reset measures from reset release.
- Start pulse FSM per channel, states IDLE, PULSE:
  - IDLE & i_Start[c] & i_Pulse_Len != 0: load the length, go to PULSE, o_Busy = 1 from the next cycle.
  - PULSE: the pin is driven low for exactly i_Pulse_Len cycles. After the last low cycle return to IDLE, and o_Done pulses in the first released cycle.
  - i_Start with length 0: no drive, o_Busy stays 0, o_Done pulses the next cycle.
  - i_Start while PULSE: ignored. The length is not reloaded.
  - i_Rst mid-pulse: release the pin at the next edge, o_Busy = 0, no o_Done.
- Channels are fully independent. Simultaneous i_Start on several channels all sample the same i_Pulse_Len.
- Simultaneous filtered edge and start-pulse completion: both strobes are issued; no priority interaction.

Decomposition:
- Package onewire_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_PULSE);
  - default constants for CNT_W and FILTER_LEN;
  - the width-counter saturation constant expression.
- Natural sub-module: onewire_pin_chan (one channel: drive mux, synchroniser, filter, edge and width logic, pulse FSM). The top is a generate loop over CHANNELS plus vector slicing.

Test Plan:
- Reset release, pin pulled high, CHANNELS = 2 -> o_Read = 2'b11, all strobes 0, o_Busy = 0; pins Z with i_Dir = 0.
- FILTER_LEN = 3, ch0 pin driven 0 for 2 cycles then 1 -> no o_Fall, o_Read stays 1. Pin held 0 for 10 cycles -> o_Fall exactly 5 clocks after the first low sample, o_Read = 0.
- ch0 low for 50 cycles, then high -> on o_Rise, o_Width_Valid = 1 and o_Width[0] = 50. Hold level > 65535 cycles (CNT_W = 16) -> next o_Width = 65535.
- i_Start[1] = 1, i_Pulse_Len = 18 -> pin 1 driven 0 for exactly 18 cycles, o_Busy high 18 cycles, o_Done 1 cycle then pin Z. A second i_Start during the pulse is ignored.
- OPEN_DRAIN = 1, i_Dir = 1, i_Send = 1 -> pin Z (pull-up reads 1); i_Send = 0 -> pin 0 and o_Read = 0 after 2+FILTER_LEN cycles.
- i_Rst asserted at cycle 5 of a 20-cycle pulse -> pin released next edge, o_Busy = 0, no o_Done, o_Read returns to 1.

Source files
------------

// File: rtl/onewire_pkg.sv
// onewire_pkg: shared state encoding, defaults and saturation limit for the single-wire pin controller
package onewire_pkg;
  typedef enum logic {ST_IDLE, ST_PULSE} pulse_state_e;
  localparam int CNT_W_DEF = 16;
  localparam int FILTER_LEN_DEF = 3;
  function automatic logic [63:0] sat_max(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/onewire_pin_chan.sv
// onewire_pin_chan: one bus pin - drive mux, sync/filter, edge and width measurement, start pulse
module onewire_pin_chan
  import onewire_pkg::*;
#(
  parameter int   CNT_W      = CNT_W_DEF,
  parameter int   FILTER_LEN = FILTER_LEN_DEF,
  parameter logic OPEN_DRAIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin,
  input  logic             dir,
  input  logic             send,
  input  logic             start,
  input  logic [CNT_W-1:0] pulse_len,
  output logic             drive_en,
  output logic             drive_val,
  output logic             read,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] width,
  output logic             width_valid,
  output logic             busy,
  output logic             done
);
  localparam int FW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] F_ONE = FW'(1);
  localparam logic [CNT_W-1:0] W_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(sat_max(CNT_W));
  pulse_state_e state, state_n;
  logic [1:0] sync;
  logic [FW-1:0] fcnt;
  logic [CNT_W-1:0] wcnt, rem, rem_n;
  logic accept, load, last, done_n;
  assign busy = state == ST_PULSE;
  assign drive_en = busy || (dir && (!OPEN_DRAIN || !send));
  assign drive_val = !busy && !OPEN_DRAIN && send;
  assign accept = sync[1] != read && fcnt == F_LAST;
  always_comb begin
    load = !busy && start && |pulse_len;
    last = busy && rem == W_ONE;
    state_n = load ? ST_PULSE : last ? ST_IDLE : state;
    rem_n = load ? pulse_len : busy ? rem - W_ONE : rem;
    done_n = last || (!busy && start && !(|pulse_len));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      fcnt <= '0;
      read <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
      width <= '0;
      width_valid <= 1'b0;
      wcnt <= '0;
      state <= ST_IDLE;
      rem <= '0;
      done <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      fcnt <= (accept || sync[1] == read) ? '0 : fcnt + F_ONE;
      read <= accept ? sync[1] : read;
      rise <= accept && sync[1];
      fall <= accept && !sync[1];
      width <= accept ? wcnt : width;
      width_valid <= accept;
      wcnt <= accept ? W_ONE : (wcnt == W_MAX ? wcnt : wcnt + W_ONE);
      state <= state_n;
      rem <= rem_n;
      done <= done_n;
    end
  end
endmodule

// File: rtl/onewire_pin_ctrl.sv
// onewire_pin_ctrl: multi-channel bidirectional single-wire pin controller
module onewire_pin_ctrl
  import onewire_pkg::*;
#(
  parameter int   CHANNELS   = 1,
  parameter int   CNT_W      = CNT_W_DEF,
  parameter int   FILTER_LEN = FILTER_LEN_DEF,
  parameter logic OPEN_DRAIN = 1'b1
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  inout  wire  [CHANNELS-1:0]       i_Port,
  input  logic [CHANNELS-1:0]       i_Dir,
  input  logic [CHANNELS-1:0]       i_Send,
  input  logic [CHANNELS-1:0]       i_Start,
  input  logic [CNT_W-1:0]          i_Pulse_Len,
  output logic [CHANNELS-1:0]       o_Read,
  output logic [CHANNELS-1:0]       o_Rise,
  output logic [CHANNELS-1:0]       o_Fall,
  output logic [CHANNELS*CNT_W-1:0] o_Width,
  output logic [CHANNELS-1:0]       o_Width_Valid,
  output logic [CHANNELS-1:0]       o_Busy,
  output logic [CHANNELS-1:0]       o_Done
);
  logic [CHANNELS-1:0] drive_en, drive_val;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign i_Port[c] = drive_en[c] ? drive_val[c] : 1'bz;
    onewire_pin_chan #(
      .CNT_W(CNT_W),
      .FILTER_LEN(FILTER_LEN),
      .OPEN_DRAIN(OPEN_DRAIN)
    ) u_chan (
      .clk(i_Clk),
      .rst(i_Rst),
      .pin(i_Port[c]),
      .dir(i_Dir[c]),
      .send(i_Send[c]),
      .start(i_Start[c]),
      .pulse_len(i_Pulse_Len),
      .drive_en(drive_en[c]),
      .drive_val(drive_val[c]),
      .read(o_Read[c]),
      .rise(o_Rise[c]),
      .fall(o_Fall[c]),
      .width(o_Width[c*CNT_W +: CNT_W]),
      .width_valid(o_Width_Valid[c]),
      .busy(o_Busy[c]),
      .done(o_Done[c])
    );
  end
endmodule

// File: tb/tb_onewire_pin_ctrl.sv
// tb_onewire_pin_ctrl: directed and randomized checks of onewire_pin_ctrl against a behavioural model
module tb_onewire_pin_ctrl;
  localparam int CH = 2;
  localparam int W = 16;
  localparam int F = 3;
  localparam longint WMAX = 65535;
  logic clk = 1'b0;
  logic rst;
  wire [CH-1:0] pin;
  logic [CH-1:0] tb_low, dir, send, start;
  logic [W-1:0] plen;
  logic [CH-1:0] rd, rise, fall, wv, busy, done;
  logic [CH*W-1:0] width;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  assign pin[0] = tb_low[0] ? 1'b0 : 1'bz;
  assign pin[1] = tb_low[1] ? 1'b0 : 1'bz;
  pullup (pin[0]);
  pullup (pin[1]);
  onewire_pin_ctrl #(
    .CHANNELS(CH),
    .CNT_W(W),
    .FILTER_LEN(F),
    .OPEN_DRAIN(1'b1)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_Port(pin),
    .i_Dir(dir),
    .i_Send(send),
    .i_Start(start),
    .i_Pulse_Len(plen),
    .o_Read(rd),
    .o_Rise(rise),
    .o_Fall(fall),
    .o_Width(width),
    .o_Width_Valid(wv),
    .o_Busy(busy),
    .o_Done(done)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  longint k = 0;
  bit armed = 0;
  logic acc;
  logic [CH-1:0] e_read = '1, e_rise = '0, e_fall = '0, e_wv = '0, e_busy = '0, e_done = '0, e_pin;
  logic [W-1:0] e_w [CH];
  longint last_edge [CH];
  longint pulse_end [CH];
  logic [F:0] hist [CH];
  always @(negedge clk) begin
    e_pin = ~(tb_low | e_busy | (dir & ~send));
    if (armed) begin
      chk("read", rd, e_read);
      chk("rise", rise, e_rise);
      chk("fall", fall, e_fall);
      chk("width_valid", wv, e_wv);
      chk("width", width, {e_w[1], e_w[0]});
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("pin", pin, e_pin);
    end
    k++;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        hist[c] = '1;
        e_read[c] = 1'b1;
        e_rise[c] = 1'b0;
        e_fall[c] = 1'b0;
        e_wv[c] = 1'b0;
        e_w[c] = '0;
        last_edge[c] = k + 1;
        pulse_end[c] = 0;
        e_busy[c] = 1'b0;
        e_done[c] = 1'b0;
      end else begin
        acc = hist[c][F:1] == {F{~e_read[c]}};
        hist[c] = {hist[c][F-1:0], e_pin[c]};
        e_rise[c] = acc && !e_read[c];
        e_fall[c] = acc && e_read[c];
        e_wv[c] = acc;
        if (acc) begin
          e_w[c] = W'((k - last_edge[c] > WMAX) ? WMAX : k - last_edge[c]);
          last_edge[c] = k;
          e_read[c] = ~e_read[c];
        end
        e_done[c] = k == pulse_end[c];
        if (!e_busy[c] && start[c]) begin
          if (plen != 0) pulse_end[c] = k + longint'(plen);
          else e_done[c] = 1'b1;
        end
        e_busy[c] = k < pulse_end[c];
      end
    end
    if (rst) armed = 1;
  end
  initial begin
    int busy_n, low_n, done_n, done_at;
    logic seen, done_pin;
    rst = 1'b1;
    tb_low = '0;
    dir = '0;
    send = '0;
    start = '0;
    plen = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_read", rd, 2'b11);
    chk("reset_strobes", {rise, fall, wv, done}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_width", width, 0);
    chk("reset_pins_released", pin, 2'b11);
    seen = 1'b0;
    tb_low[0] = 1'b1;
    tick(2);
    tb_low[0] = 1'b0;
    repeat (8) begin
      tick(1);
      seen |= fall[0] | ~rd[0];
    end
    chk("glitch_rejected", seen, 0);
    tb_low[0] = 1'b1;
    tick(4);
    chk("fall_not_early", fall[0], 0);
    chk("read_not_early", rd[0], 1);
    tick(1);
    chk("fall_at_5", fall[0], 1);
    chk("read_low_at_5", rd[0], 0);
    chk("width_valid_at_fall", wv[0], 1);
    tick(45);
    tb_low[0] = 1'b0;
    tick(4);
    chk("rise_not_early", rise[0], 0);
    tick(1);
    chk("rise_at_5", rise[0], 1);
    chk("width_valid_at_rise", wv[0], 1);
    chk("width_50", width[W-1:0], 50);
    tick(65540);
    tb_low[0] = 1'b1;
    tick(5);
    chk("fall_after_long_high", fall[0], 1);
    chk("width_saturated", width[W-1:0], 16'hFFFF);
    tb_low[0] = 1'b0;
    start[1] = 1'b1;
    plen = 18;
    tick(1);
    start[1] = 1'b0;
    busy_n = 0;
    low_n = 0;
    done_n = 0;
    done_at = -1;
    done_pin = 1'b0;
    for (int j = 0; j < 25; j++) begin
      busy_n += int'(busy[1]);
      low_n += int'(!pin[1]);
      if (done[1]) begin
        done_n++;
        done_at = j;
        done_pin = pin[1];
      end
      start[1] = j == 4;
      if (j == 4) plen = 3;
      tick(1);
    end
    chk("pulse_busy_cycles", busy_n, 18);
    chk("pulse_low_cycles", low_n, 18);
    chk("pulse_done_count", done_n, 1);
    chk("pulse_done_time", done_at, 18);
    chk("pulse_done_released", done_pin, 1);
    dir[0] = 1'b1;
    send[0] = 1'b1;
    tick(1);
    chk("od_send1_released", pin[0], 1);
    send[0] = 1'b0;
    tick(1);
    chk("od_send0_driven", pin[0], 0);
    tick(3);
    chk("od_read_not_early", rd[0], 1);
    tick(1);
    chk("od_readback_low", rd[0], 0);
    chk("od_fall", fall[0], 1);
    dir[0] = 1'b0;
    tick(10);
    start[1] = 1'b1;
    plen = 20;
    tick(1);
    start[1] = 1'b0;
    tick(4);
    chk("abort_busy_before", busy[1], 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy_cleared", busy[1], 0);
    chk("abort_pin_released", pin[1], 1);
    chk("abort_no_done", done[1], 0);
    seen = 1'b0;
    repeat (10) begin
      tick(1);
      seen |= done[1];
    end
    chk("abort_no_late_done", seen, 0);
    chk("abort_read_high", rd, 2'b11);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 599) == 0;
      if ($urandom_range(0, 6) == 0) tb_low = CH'($urandom);
      if ($urandom_range(0, 19) == 0) dir = CH'($urandom);
      if ($urandom_range(0, 9) == 0) send = CH'($urandom);
      start = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
      plen = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 25));
      tick(1);
    end
    rst = 1'b0;
    start = '0;
    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
